// File: rtl/load_store_unit.sv
// RV32I load/store unit over a word-wide data memory; sub-word stores use read-modify-write.
// Build option LSU_MISALIGN_ERR_EN: misaligned accesses respond with an error instead of being truncated.
module load_store_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [2:0]        i_req_funct3,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [DATA_W-1:0] i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] o_resp_data,
    output logic              o_resp_err,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [DATA_W-1:0] o_mem_data_write,
    output logic              o_mem_write_en,
    input  logic [DATA_W-1:0] i_mem_data,
    output logic              o_busy
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wword_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic [2:0]        cnt_q;
    logic              accept;
    logic              req_illegal;
    logic              req_misalign;
    logic              req_err;

    function automatic logic [DATA_W-1:0] load_extend(input logic [DATA_W-1:0] word,
                                                      input logic [2:0] funct3,
                                                      input logic [1:0] lane);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = word[{lane[1], 4'b0000} +: 16];
        case (funct3)
            3'b000:  load_extend = {{24{b[7]}}, b};
            3'b001:  load_extend = {{16{h[15]}}, h};
            3'b100:  load_extend = {24'h000000, b};
            3'b101:  load_extend = {16'h0000, h};
            default: load_extend = word;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_merge(input logic [DATA_W-1:0] word,
                                                      input logic [15:0] wdata,
                                                      input logic [2:0] funct3,
                                                      input logic [1:0] lane);
        store_merge = word;
        if (funct3[1:0] == 2'b00)
            store_merge[{lane, 3'b000} +: 8] = wdata[7:0];
        else
            store_merge[{lane[1], 4'b0000} +: 16] = wdata;
    endfunction

    always_comb begin
        if (i_req_we)
            req_illegal = !(i_req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            req_illegal = !(i_req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    end

`ifdef LSU_MISALIGN_ERR_EN
    assign req_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                          ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    // Misaligned accesses are truncated by the word address and lane select.
    assign req_misalign = 1'b0;
`endif

    assign req_err = req_illegal || req_misalign;
    assign accept  = i_req_valid && (state_q == IDLE);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (req_err)
                        state_d = RESP;
                    else if (i_req_we && (i_req_funct3 == 3'b010))
                        state_d = WRITE;
                    else
                        state_d = READ;
                end
            end
            READ:    if (cnt_q == 3'd0) state_d = we_q ? WRITE : RESP;
            WRITE:   state_d = RESP;
            RESP:    if (i_resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, read-wait counter and result capture
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wword_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
            cnt_q    <= 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        we_q     <= i_req_we;
                        funct3_q <= i_req_funct3;
                        addr_q   <= i_req_addr;
                        wword_q  <= i_req_wdata;
                        rdata_q  <= '0;
                        err_q    <= req_err;
                        cnt_q    <= 3'(MEM_LAT);
                    end
                end
                READ: begin
                    if (cnt_q == 3'd0) begin
                        if (we_q)
                            wword_q <= store_merge(i_mem_data, wword_q[15:0], funct3_q, addr_q[1:0]);
                        else
                            rdata_q <= load_extend(i_mem_data, funct3_q, addr_q[1:0]);
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready      = (state_q == IDLE) && i_reset_n;
    assign o_busy           = (state_q != IDLE);
    assign o_resp_valid     = (state_q == RESP);
    assign o_resp_data      = (state_q == RESP) ? rdata_q : '0;
    assign o_resp_err       = (state_q == RESP) && err_q;
    assign o_mem_addr       = (state_q != IDLE) ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign o_mem_data_write = (state_q == WRITE) ? wword_q : '0;
    // Gated with reset so a write strobe cannot outlive reset assertion.
    assign o_mem_write_en   = (state_q == WRITE) && i_reset_n;
endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed and random requests against an arithmetic reference model.
module tb_load_store_unit;
    localparam int L = 1;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_we = 1'b0;
    logic [2:0]  i_req_funct3 = 3'b000;
    logic [31:0] i_req_addr = 32'h0;
    logic [31:0] i_req_wdata = 32'h0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [31:0] o_resp_data;
    logic        o_resp_err;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_data_write;
    logic        o_mem_write_en;
    logic [31:0] i_mem_data;
    logic        o_busy;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic [31:0] pipe [L];
    logic        init_mem = 1'b0;
    int          wr_count = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [31:0] last_waddr = 32'h0;
    int          n_checks = 0;
    int          n_fail = 0;

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .MEM_LAT(L)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_funct3(i_req_funct3),
        .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_data(o_resp_data), .o_resp_err(o_resp_err),
        .o_mem_addr(o_mem_addr), .o_mem_data_write(o_mem_data_write),
        .o_mem_write_en(o_mem_write_en), .i_mem_data(i_mem_data),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Memory with L-cycle read latency, word writes on the strobe
    assign i_mem_data = pipe[L-1];
    always @(posedge i_clk) begin
        pipe[0] <= mem[o_mem_addr[7:2]];
        for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
        if (init_mem) begin
            for (int i = 0; i < 64; i++) mem[i] <= ref_mem[i];
        end else if (o_mem_write_en) begin
            mem[o_mem_addr[7:2]] <= o_mem_data_write;
            wr_count   <= wr_count + 1;
            last_wdata <= o_mem_data_write;
            last_waddr <= o_mem_addr;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                  input logic [31:0] wd, input logic [31:0] word,
                                  output logic [31:0] data, output logic err, output logic wr,
                                  output logic [31:0] wword, output int lat);
        logic legal, mis;
        int size_b, off;
        logic [31:0] mask, v;
        legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        size_b = 1 << f3[1:0];
        mis = (addr % size_b) != 0;
`ifdef LSU_MISALIGN_ERR_EN
        err = !legal || mis;
`else
        err = !legal;
`endif
        off = addr % 4;
        off = off - (off % size_b);
        mask = (size_b == 1) ? 32'hFF : (size_b == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        data = 32'h0; wr = 1'b0; wword = 32'h0;
        if (err) begin
            lat = 1;
        end else if (we) begin
            wr = 1'b1;
            if (size_b == 4) begin
                wword = wd; lat = 2;
            end else begin
                wword = (word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off));
                lat = L + 3;
            end
        end else begin
            v = (word >> (8 * off)) & mask;
            if (!f3[2] && size_b < 4 && v[8 * size_b - 1]) v = v | ~mask;
            data = v; lat = L + 2;
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".req_ready"}, {31'h0, o_req_ready}, 32'h0);
        chk({tag, ".resp_valid"}, {31'h0, o_resp_valid}, 32'h0);
        chk({tag, ".resp_data"}, o_resp_data, 32'h0);
        chk({tag, ".resp_err"}, {31'h0, o_resp_err}, 32'h0);
        chk({tag, ".mem_addr"}, o_mem_addr, 32'h0);
        chk({tag, ".mem_wdata"}, o_mem_data_write, 32'h0);
        chk({tag, ".mem_we"}, {31'h0, o_mem_write_en}, 32'h0);
        chk({tag, ".busy"}, {31'h0, o_busy}, 32'h0);
    endtask

    task automatic run_op(input string tag, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int hold);
        logic [31:0] exp_d, exp_w, word, d0;
        logic exp_e, exp_wr, e0;
        int exp_lat, k, wr_k, wr_before;
        word = ref_mem[addr[7:2]];
        model(we, f3, addr, wd, word, exp_d, exp_e, exp_wr, exp_w, exp_lat);
        @(negedge i_clk);
        chk({tag, ".req_ready"}, {31'h0, o_req_ready}, 32'h1);
        i_req_valid = 1'b1; i_req_we = we; i_req_funct3 = f3; i_req_addr = addr; i_req_wdata = wd;
        wr_before = wr_count;
        @(posedge i_clk); #1;
        // Keep presenting junk requests while busy; they must be ignored
        i_req_we = 1'($urandom); i_req_funct3 = 3'($urandom); i_req_addr = $urandom; i_req_wdata = $urandom;
        chk({tag, ".mem_addr"}, o_mem_addr, {addr[31:2], 2'b00});
        k = 1; wr_k = 0;
        while (o_resp_valid !== 1'b1 && k < 40) begin
            if (o_mem_write_en === 1'b1) wr_k = k;
            @(posedge i_clk); #1;
            k++;
        end
        i_req_valid = 1'b0;
        chk({tag, ".latency"}, k, exp_lat);
        chk({tag, ".data"}, o_resp_data, exp_d);
        chk({tag, ".err"}, {31'h0, o_resp_err}, {31'h0, exp_e});
        chk({tag, ".req_ready_resp"}, {31'h0, o_req_ready}, 32'h0);
        chk({tag, ".mem_we_resp"}, {31'h0, o_mem_write_en}, 32'h0);
        chk({tag, ".wr_pulses"}, wr_count - wr_before, exp_wr ? 1 : 0);
        if (exp_wr) begin
            chk({tag, ".wr_cycle"}, wr_k, exp_lat - 1);
            chk({tag, ".wr_data"}, last_wdata, exp_w);
            chk({tag, ".wr_addr"}, last_waddr, {addr[31:2], 2'b00});
            ref_mem[addr[7:2]] = exp_w;
        end
        d0 = o_resp_data; e0 = o_resp_err;
        for (int i = 0; i < hold; i++) begin
            @(posedge i_clk); #1;
            chk({tag, ".hold_valid"}, {31'h0, o_resp_valid}, 32'h1);
            chk({tag, ".hold_data"}, o_resp_data, d0);
            chk({tag, ".hold_err"}, {31'h0, o_resp_err}, {31'h0, e0});
            chk({tag, ".hold_ready"}, {31'h0, o_req_ready}, 32'h0);
        end
        @(negedge i_clk);
        i_resp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_resp_ready = 1'b0;
        chk({tag, ".after_valid"}, {31'h0, o_resp_valid}, 32'h0);
        chk({tag, ".after_ready"}, {31'h0, o_req_ready}, 32'h1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved;
        int wr_before;
        for (int i = 0; i < 64; i++) ref_mem[i] = $urandom;
        ref_mem[4] = 32'h8899AABB;
        ref_mem[8] = 32'h11223344;
        pipe[0] = 32'h0;
        #3 i_reset_n = 1'b0;
        #2 check_reset_outputs("reset");
        @(negedge i_clk); init_mem = 1'b1;
        @(negedge i_clk); init_mem = 1'b0;
        i_reset_n = 1'b1;
        #1 chk("reset_release.req_ready", {31'h0, o_req_ready}, 32'h1);

        run_op("lw_10",  1'b0, 3'b010, 32'h10, 32'h0, 0);
        run_op("lb_13",  1'b0, 3'b000, 32'h13, 32'h0, 0);
        run_op("lbu_13", 1'b0, 3'b100, 32'h13, 32'h0, 0);
        run_op("lh_12",  1'b0, 3'b001, 32'h12, 32'h0, 0);
        run_op("lhu_12", 1'b0, 3'b101, 32'h12, 32'h0, 1);
        run_op("sb_21",  1'b1, 3'b000, 32'h21, 32'h000000CC, 0);
        run_op("lw_20",  1'b0, 3'b010, 32'h20, 32'h0, 0);
        run_op("sw_30",  1'b1, 3'b010, 32'h30, 32'hDEADBEEF, 0);
        run_op("sh_36",  1'b1, 3'b001, 32'h36, 32'h0000A5A5, 0);
        run_op("lw_02",  1'b0, 3'b010, 32'h02, 32'h0, 0);
        run_op("lh_odd", 1'b0, 3'b001, 32'h15, 32'h0, 0);
        run_op("sw_mis", 1'b1, 3'b010, 32'h2B, 32'h12345678, 0);
        run_op("ld_f3_3", 1'b0, 3'b011, 32'h10, 32'h0, 0);
        run_op("st_f3_4", 1'b1, 3'b100, 32'h10, 32'hFFFFFFFF, 0);
        run_op("hold5",  1'b0, 3'b000, 32'h11, 32'h0, 5);

        // Reset during the read phase of a byte store
        saved = ref_mem[9];
        @(negedge i_clk);
        i_req_valid = 1'b1; i_req_we = 1'b1; i_req_funct3 = 3'b000;
        i_req_addr = 32'h25; i_req_wdata = 32'h5A;
        wr_before = wr_count;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        chk("rst_mid.busy", {31'h0, o_busy}, 32'h1);
        #2 i_reset_n = 1'b0;
        #1 check_reset_outputs("rst_mid");
        repeat (4) @(posedge i_clk);
        #1 chk("rst_mid.no_write", wr_count - wr_before, 0);
        chk("rst_mid.mem_kept", mem[9], saved);
        check_reset_outputs("rst_held");
        @(negedge i_clk); i_reset_n = 1'b1;
        #1 chk("rst_mid.ready", {31'h0, o_req_ready}, 32'h1);

        for (int n = 0; n < 80; n++) begin
            run_op("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 255)), $urandom, $urandom_range(0, 2));
        end
        for (int i = 0; i < 64; i++) chk("final_mem", mem[i], ref_mem[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
